// File: rtl/dff_pkg.sv
// dff_pkg: shared helpers for dff_pipe (clog2, parity, occupancy width rule)
package dff_pkg;
    localparam int MAX_W = 1024;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int occ_width(input int depth);
        return clog2(depth + 1);
    endfunction
    // zero-extension leaves even parity unchanged, so one wide argument serves every WIDTH
    function automatic logic parity(input logic [MAX_W-1:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/dff_stage.sv
// dff_stage: one enable/flush-able register stage with async active-low reset
module dff_stage #(
    parameter int W = 9,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= RST_VAL;
        else if (flush) q <= RST_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage valid-tagged register pipeline with occupancy count;
// optional per-stage parity protection when DFF_PIPE_PARITY_EN is defined.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            din,
    input  logic                        din_vld,
    input  logic                        err_inj,
    output logic [WIDTH-1:0]            dout,
    output logic                        dout_vld,
    output logic [occ_width(DEPTH)-1:0] occ,
    output logic                        par_err
);
    localparam int OCC_W = occ_width(DEPTH);
    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipe: DEPTH must be >= 1");
    end
`ifdef DFF_PIPE_PARITY_EN
    localparam int PW = WIDTH + 2;
    localparam logic [PW-1:0] ST_RST = {1'b0, parity(MAX_W'(RST_VAL)), RST_VAL};
    logic [PW-1:0] head;
    assign head = {din_vld, parity(MAX_W'(din)) ^ err_inj, din};
`else
    localparam int PW = WIDTH + 1;
    localparam logic [PW-1:0] ST_RST = {1'b0, RST_VAL};
    logic [PW-1:0] head;
    logic unused_err_inj;
    assign head = {din_vld, din};
    assign unused_err_inj = err_inj;
`endif
    logic [DEPTH-1:0][PW-1:0] st;
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [PW-1:0] d;
        if (g == 0) begin : g_head
            assign d = head;
        end else begin : g_link
            assign d = st[g-1];
        end
        dff_stage #(.W(PW), .RST_VAL(ST_RST)) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .flush (flush),
            .d     (d),
            .q     (st[g])
        );
    end
    assign dout     = st[DEPTH-1][WIDTH-1:0];
    assign dout_vld = st[DEPTH-1][PW-1];
    // a valid entry can only leave when occ >= 1, so this never underflows
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) occ <= '0;
        else if (flush) occ <= '0;
        else if (en) occ <= occ + OCC_W'(din_vld) - OCC_W'(dout_vld);
`ifdef DFF_PIPE_PARITY_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) par_err <= 1'b0;
        else if (flush) par_err <= 1'b0;
        else par_err <= dout_vld & (parity(MAX_W'(dout)) != st[DEPTH-1][WIDTH]);
`else
    assign par_err = 1'b0;
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed + random checks of dff_pipe against a queue-based model
module tb_dff_pipe;
    localparam int W = 8;
    localparam int D = 4;
    localparam logic [W-1:0] RV = 8'h5A;

    logic clk = 0, rst_n = 0, en = 0, flush = 0, din_vld = 0, err_inj = 0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic dout_vld, par_err;
    logic [2:0] occ;
    int n_vec = 0, n_bad = 0;

    typedef struct packed {logic v; logic c; logic [W-1:0] d;} ent_t;
    ent_t pipe[$];
    logic exp_pe;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .din(din),
        .din_vld(din_vld), .err_inj(err_inj), .dout(dout),
        .dout_vld(dout_vld), .occ(occ), .par_err(par_err)
    );

    function automatic void model_reset();
        pipe.delete();
        for (int i = 0; i < D; i++) pipe.push_back('{v: 1'b0, c: 1'b0, d: RV});
        exp_pe = 1'b0;
    endfunction

    function automatic int model_occ();
        int n = 0;
        foreach (pipe[i]) n += int'(pipe[i].v);
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"}, 32'(dout), 32'(pipe[D-1].d));
        check({tag, ".vld"}, 32'(dout_vld), 32'(pipe[D-1].v));
        check({tag, ".occ"}, 32'(occ), 32'(model_occ()));
`ifdef DFF_PIPE_PARITY_EN
        check({tag, ".perr"}, 32'(par_err), 32'(exp_pe));
`else
        check({tag, ".perr"}, 32'(par_err), 32'(0));
`endif
    endtask

    task automatic step(input logic e, input logic f, input logic v, input logic [W-1:0] d,
                        input logic inj, input string tag);
        en = e; flush = f; din_vld = v; din = d; err_inj = inj;
        @(posedge clk);
        if (f) model_reset();
        else begin
            exp_pe = pipe[D-1].v & pipe[D-1].c;
            if (e) begin
                pipe.push_front('{v: v, c: inj, d: d});
                pipe = pipe[0:D-1];
            end
        end
        #1 check_all(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < D + 1; i++) step(1, 0, 0, 8'h00, 0, "drain");
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1;
        @(negedge clk);
        check_all("reset");
        check("reset_dout_const", 32'(dout), 32'(RV));

        // latency: single valid word through four stages
        step(1, 0, 1, 8'hA5, 0, "lat");
        check("lat_occ1", 32'(occ), 32'(1));
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 0, "lat");
        check("lat_dout", 32'(dout), 32'hA5);
        check("lat_vld", 32'(dout_vld), 32'(1));
        step(1, 0, 0, 8'h00, 0, "lat");
        check("lat_occ0", 32'(occ), 32'(0));

        // stall for two cycles after the second edge
        step(1, 0, 1, 8'hA5, 0, "stall");
        step(1, 0, 0, 8'h11, 0, "stall");
        step(0, 0, 1, 8'h22, 0, "stall");
        step(0, 0, 1, 8'h33, 0, "stall");
        check("stall_occ_hold", 32'(occ), 32'(1));
        step(1, 0, 0, 8'h44, 0, "stall");
        check("stall_not_yet", 32'(dout_vld), 32'(0));
        step(1, 0, 0, 8'h55, 0, "stall");
        check("stall_dout", 32'(dout), 32'hA5);
        drain();

        // flush wins over a simultaneous enabled write
        for (int i = 0; i < 3; i++) step(1, 0, 1, 8'(8'h10 + i), 0, "fill3");
        check("flush_pre_occ", 32'(occ), 32'(3));
        step(1, 1, 1, 8'hFF, 0, "flush");
        check("flush_occ", 32'(occ), 32'(0));
        check("flush_dout", 32'(dout), 32'(RV));
        drain();

        // continuous stream saturates occ at DEPTH
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 8'(i * 17 + 3), 0, "stream");
            check("stream_occ", 32'(occ), 32'(i + 1 < D ? i + 1 : D));
        end
        drain();

        // injected parity error on 0x3C
        step(1, 0, 1, 8'h3C, 1, "perr");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 0, "perr");
        check("perr_dout", 32'(dout), 32'h3C);
        check("perr_early", 32'(par_err), 32'(0));
        step(1, 0, 0, 8'h00, 0, "perr");
`ifdef DFF_PIPE_PARITY_EN
        check("perr_flag", 32'(par_err), 32'(1));
`else
        check("perr_flag", 32'(par_err), 32'(0));
`endif
        step(1, 0, 0, 8'h00, 0, "perr");
        check("perr_clear", 32'(par_err), 32'(0));

        // asynchronous reset mid-stream, no clock edge
        for (int i = 0; i < 3; i++) step(1, 0, 1, 8'(8'hC0 + i), 0, "pre_rst");
        en = 1; din_vld = 1;
        rst_n = 0;
        #2;
        model_reset();
        check_all("async_rst");
        check("async_rst_dout", 32'(dout), 32'(RV));
        @(negedge clk) rst_n = 1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 0;
                #1 model_reset();
                check_all("rnd_rst");
                @(negedge clk) rst_n = 1;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom),
                 8'($urandom), $urandom_range(0, 7) == 0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
